prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : UART (8N1) program loader. It receives a one-byte word count
//                N followed by N little-endian 32-bit words and writes them
//                to the instruction memory. The datapath is held in reset
//                until the whole program has arrived.
//
//  Ports
//    clk          in   1   system clock, all state on the rising edge
//    reset        in   1   asynchronous active-high reset
//    rx           in   1   UART serial input (idle high, 8N1, LSB first)
//    imem_we      out  1   one-cycle instruction-memory write strobe
//    imem_addr    out  6   word address (instruction-memory addr[7:2])
//    imem_wdata   out  32  assembled instruction word
//    core_reset   out  1   high holds the datapath in reset
//    load_done    out  1   high once the program is completely loaded
//    frame_err    out  1   sticky framing-error flag
//    words_loaded out  7   number of words written to memory
//
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        imem_we,
    output logic [5:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        load_done,
    output logic        frame_err,
    output logic [6:0]  words_loaded
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_HALF  = CLKS_PER_BIT / 2;

    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
    // Guard against CLKS_PER_BIT < 2, where the half-bit point would be zero.
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'((c_HALF > 0) ? (c_HALF - 1) : 0);
    localparam logic [5:0]         c_ADDR_MAX = 6'(DEPTH - 1);
    localparam logic [8:0]         c_DEPTH9   = 9'(DEPTH);
    localparam logic [6:0]         c_WL_MAX   = 7'(DEPTH);

    // ------------------------------------------------------------------------
    // State encodings
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        L_HDR  = 2'd0,
        L_LOAD = 2'd1,
        L_DONE = 2'd2,
        L_ERR  = 2'd3
    } ld_state_t;

    // ------------------------------------------------------------------------
    // Receiver signals
    // ------------------------------------------------------------------------
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    rx_state_t          r_rx_state;
    rx_state_t          w_rx_next;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_byte;
    logic               r_byte_valid;
    logic               r_rx_ferr;
    logic               w_fall;
    logic               w_tick;

    // ------------------------------------------------------------------------
    // Loader signals
    // ------------------------------------------------------------------------
    ld_state_t          r_ld_state;
    ld_state_t          w_ld_next;
    logic [7:0]         r_n;
    logic [7:0]         r_word_idx;
    logic [1:0]         r_byte_idx;
    logic [23:0]        r_partial;
    logic               r_we;
    logic               r_last_wr;
    logic [5:0]         r_addr;
    logic [31:0]        r_wdata;
    logic [6:0]         r_words_loaded;
    logic               r_load_done;
    logic               r_core_reset;
    logic               r_frame_err;
    logic               w_word_done;
    logic               w_in_range;
    logic               w_last;

    // ------------------------------------------------------------------------
    // Input synchronizer. The extra r_rx_prev stage gives a clean edge detect
    // on the synchronized signal; all three flops reset to the idle level so
    // no false start bit is seen right after reset release.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_sync;
    // The start bit is checked at its midpoint; every later bit one full bit
    // period after the previous sample, so samples stay centred.
    assign w_tick = (r_rx_state == RX_START) ? (r_clk_cnt == c_HALF_M1)
                                             : (r_clk_cnt == c_FULL_M1);

    // ------------------------------------------------------------------------
    // Receiver FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // ------------------------------------------------------------------------
    // Receiver FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_rx_next = RX_START;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    // High at mid start bit is a glitch, not a character.
                    w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_tick && (r_bit_cnt == 3'd7)) begin
                    w_rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    w_rx_next = RX_IDLE;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Receiver datapath: bit timing, shift register, byte / error pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_cnt    <= '0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_byte       <= 8'd0;
            r_byte_valid <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_rx_ferr    <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_cnt <= 3'd0;
                end
                RX_START: begin
                    r_clk_cnt <= w_tick ? '0 : r_clk_cnt + 1'b1;
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        if (r_rx_sync) begin
                            r_byte_valid <= 1'b1;
                            r_byte       <= r_shift;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_clk_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Loader decode
    // ------------------------------------------------------------------------
    assign w_word_done = r_byte_valid && (r_ld_state == L_LOAD) && (r_byte_idx == 2'd3);
    assign w_in_range  = ({1'b0, r_word_idx} < c_DEPTH9);
    assign w_last      = (({1'b0, r_word_idx} + 9'd1) == {1'b0, r_n});

    // ------------------------------------------------------------------------
    // Loader FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_state <= L_HDR;
        end else begin
            r_ld_state <= w_ld_next;
        end
    end

    // ------------------------------------------------------------------------
    // Loader FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_ld_next = r_ld_state;
        case (r_ld_state)
            L_HDR: begin
                if (r_byte_valid) begin
                    w_ld_next = (r_byte == 8'd0) ? L_DONE : L_LOAD;
                end else if (r_rx_ferr) begin
                    w_ld_next = L_ERR;
                end
            end
            L_LOAD: begin
                if (r_rx_ferr) begin
                    w_ld_next = L_ERR;
                end else if (r_we && r_last_wr) begin
                    // Last word written: finish after its strobe cycle.
                    w_ld_next = L_DONE;
                end else if (w_word_done && w_last && !w_in_range) begin
                    // Last word discarded: no strobe to wait for.
                    w_ld_next = L_DONE;
                end
            end
            L_DONE:  w_ld_next = L_DONE;
            L_ERR:   w_ld_next = L_ERR;
            default: w_ld_next = L_ERR;
        endcase
    end

    // ------------------------------------------------------------------------
    // Loader datapath: word assembly, write strobe, address and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n            <= 8'd0;
            r_word_idx     <= 8'd0;
            r_byte_idx     <= 2'd0;
            r_partial      <= 24'd0;
            r_we           <= 1'b0;
            r_last_wr      <= 1'b0;
            r_addr         <= 6'd0;
            r_wdata        <= 32'd0;
            r_words_loaded <= 7'd0;
        end else begin
            r_we      <= 1'b0;
            r_last_wr <= 1'b0;

            if ((r_ld_state == L_HDR) && r_byte_valid) begin
                r_n        <= r_byte;
                r_word_idx <= 8'd0;
                r_byte_idx <= 2'd0;
            end else if (w_word_done) begin
                r_word_idx <= r_word_idx + 8'd1;
                r_byte_idx <= 2'd0;
                // Out-of-range words are counted but leave wdata untouched,
                // so it keeps showing the last word actually written.
                if (w_in_range) begin
                    r_we      <= 1'b1;
                    r_last_wr <= w_last;
                    r_wdata   <= {r_byte, r_partial};
                end
            end else if (r_byte_valid && (r_ld_state == L_LOAD)) begin
                case (r_byte_idx)
                    2'd0:    r_partial[7:0]   <= r_byte;
                    2'd1:    r_partial[15:8]  <= r_byte;
                    default: r_partial[23:16] <= r_byte;
                endcase
                r_byte_idx <= r_byte_idx + 2'd1;
            end

            // Address and count advance at the end of the strobe cycle so
            // they are stable while imem_we is high.
            if (r_we) begin
                if (r_addr != c_ADDR_MAX) begin
                    r_addr <= r_addr + 6'd1;
                end
                if (r_words_loaded != c_WL_MAX) begin
                    r_words_loaded <= r_words_loaded + 7'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status outputs registered from the next state so they change exactly
    // with the state and never glitch.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_done  <= 1'b0;
            r_core_reset <= 1'b1;
            r_frame_err  <= 1'b0;
        end else begin
            r_load_done  <= (w_ld_next == L_DONE);
            r_core_reset <= (w_ld_next != L_DONE);
            if (w_ld_next == L_ERR) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign core_reset   = r_core_reset;
    assign load_done    = r_load_done;
    assign frame_err    = r_frame_err;
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Programs are sent over
//                the UART line and the captured memory writes and status
//                outputs are compared against a reference derived from the
//                program contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int CPB = 4;
    localparam int DEP = 64;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        load_done;
    logic        frame_err;
    logic [6:0]  words_loaded;

    prog_loader #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .frame_err    (frame_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Write monitor: captures every strobe as {addr, data}.
    logic [37:0] got_q[$];
    int          core_low_cnt = 0;

    always @(negedge clk) begin
        if (imem_we) got_q.push_back({imem_addr, imem_wdata});
        if (!core_reset) core_low_cnt = core_low_cnt + 1;
    end

    // Program under transfer
    logic [31:0] prog[0:79];
    int          prog_n;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_prog();
        logic [31:0] w;
        send_byte(8'(prog_n), 1'b1);
        for (int k = 0; k < prog_n; k++) begin
            w = prog[k];
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b1);
        end
        repeat (4) @(negedge clk);
    endtask

    // Reference: word i of the program lands at address i while i < DEP;
    // everything beyond is dropped and the count saturates at DEP.
    task automatic check_result(input string tag, input int base);
        int          exp_w;
        logic [37:0] e;
        exp_w = (prog_n < DEP) ? prog_n : DEP;
        chk({tag, "_nwrites"}, 64'(got_q.size() - base), 64'(exp_w));
        for (int i = 0; i < exp_w; i++) begin
            if (base + i < got_q.size()) begin
                e = {6'(i), prog[i]};
                chk({tag, "_write"}, 64'(got_q[base + i]), 64'(e));
            end
        end
        chk({tag, "_load_done"},    64'(load_done),    64'd1);
        chk({tag, "_core_reset"},   64'(core_reset),   64'd0);
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_w));
        chk({tag, "_frame_err"},    64'(frame_err),    64'd0);
    endtask

    task automatic load_fixed();
        prog_n  = 2;
        prog[0] = 32'h0050_0013;
        prog[1] = 32'h00A0_0093;
    endtask

    initial begin
        int          base;
        int          low0;
        logic [31:0] wd_snap;
        logic [6:0]  wl_snap;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_we",     64'(imem_we),      64'd0);
        chk("rst_addr",   64'(imem_addr),    64'd0);
        chk("rst_wdata",  64'(imem_wdata),   64'd0);
        chk("rst_core",   64'(core_reset),   64'd1);
        chk("rst_done",   64'(load_done),    64'd0);
        chk("rst_ferr",   64'(frame_err),    64'd0);
        chk("rst_wl",     64'(words_loaded), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- basic two-word program ----------------
        load_fixed();
        base = got_q.size();
        send_prog();
        check_result("basic", base);

        // Traffic after completion must be ignored, including bad frames.
        base    = got_q.size();
        wd_snap = imem_wdata;
        wl_snap = words_loaded;
        send_byte(8'h55, 1'b1);
        send_byte(8'hA7, 1'b0);
        send_byte(8'h12, 1'b1);
        repeat (4) @(negedge clk);
        chk("post_nwrites", 64'(got_q.size() - base), 64'd0);
        chk("post_wdata",   64'(imem_wdata),          64'(wd_snap));
        chk("post_wl",      64'(words_loaded),        64'(wl_snap));
        chk("post_done",    64'(load_done),           64'd1);
        chk("post_ferr",    64'(frame_err),           64'd0);

        // ---------------- empty program ----------------
        do_reset();
        prog_n = 0;
        base   = got_q.size();
        send_prog();
        check_result("empty", base);

        // ---------------- glitch on idle line ----------------
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_ferr", 64'(frame_err),   64'd0);
        chk("glitch_done", 64'(load_done),   64'd0);
        chk("glitch_core", 64'(core_reset),  64'd1);
        load_fixed();
        base = got_q.size();
        send_prog();
        check_result("glitch_then", base);

        // ---------------- framing error mid word ----------------
        do_reset();
        base = got_q.size();
        low0 = core_low_cnt;
        send_byte(8'd1, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        chk("ferr_flag",    64'(frame_err),              64'd1);
        chk("ferr_nwrites", 64'(got_q.size() - base),    64'd0);
        chk("ferr_core",    64'(core_reset),             64'd1);
        chk("ferr_corelow", 64'(core_low_cnt - low0),    64'd0);
        chk("ferr_done",    64'(load_done),              64'd0);

        // ---------------- overflow: 66 random words ----------------
        do_reset();
        prog_n = 66;
        for (int k = 0; k < prog_n; k++) prog[k] = $urandom;
        base = got_q.size();
        send_prog();
        check_result("ovf", base);
        chk("ovf_addr_sat", 64'(imem_addr),  64'(DEP - 1));
        chk("ovf_wdata",    64'(imem_wdata), 64'(prog[DEP - 1]));

        // ---------------- reset during third byte of word 0 ----------------
        do_reset();
        send_byte(8'd2, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        do_reset();
        chk("midrst_wl",   64'(words_loaded), 64'd0);
        chk("midrst_core", 64'(core_reset),   64'd1);
        load_fixed();
        base = got_q.size();
        send_prog();
        check_result("midrst", base);

        // ---------------- random programs ----------------
        for (int t = 0; t < 3; t++) begin
            do_reset();
            prog_n = int'($urandom_range(1, 8));
            for (int k = 0; k < prog_n; k++) prog[k] = $urandom;
            base = got_q.size();
            send_prog();
            check_result("rand", base);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
